// File: rtl/conv_row_segmenter_if.sv
// Descriptor stream from the row segmenter to the pixel-buffer read port.
// The master drives the descriptor and seg_valid; the slave returns seg_ready.
interface conv_row_segmenter_if #(
    parameter int IDX_W = 16,
    parameter int CFG_W = 4
);
    logic             seg_valid;
    logic             seg_ready;
    logic [IDX_W-1:0] row_start_idx;
    logic [IDX_W-1:0] row_end_idx;
    logic [IDX_W-1:0] reg_start_idx;
    logic [IDX_W-1:0] reg_end_idx;
    logic [CFG_W-1:0] west_pad;
    logic [CFG_W-1:0] slab_num;
    logic [CFG_W-1:0] east_pad;
    logic             seg_last;

    modport master (
        output seg_valid, row_start_idx, row_end_idx, reg_start_idx, reg_end_idx,
        output west_pad, slab_num, east_pad, seg_last,
        input  seg_ready
    );

    modport slave (
        input  seg_valid, row_start_idx, row_end_idx, reg_start_idx, reg_end_idx,
        input  west_pad, slab_num, east_pad, seg_last,
        output seg_ready
    );
endinterface

// File: rtl/conv_row_segmenter.sv
// Splits the padded input span of each output-tile row into buffer-word descriptors.
// Optional CONV_SEG_CFG_CHECK_EN adds a cfg_err pulse and refuses illegal configs at start.
module conv_row_segmenter #(
    parameter int PIXELS_IN_ROW = 32,
    parameter int IDX_W         = 16,
    parameter int CFG_W         = 4,
    parameter int ROW_W         = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [IDX_W-1:0]      ix,
    input  logic [IDX_W-1:0]      ox_start,
    input  logic [IDX_W-1:0]      pox,
    input  logic [CFG_W-1:0]      k,
    input  logic [CFG_W-1:0]      s,
    input  logic [CFG_W-1:0]      p,
    input  logic [ROW_W-1:0]      n_rows,
    conv_row_segmenter_if.master  seg,
    output logic                  done,
    output logic                  busy,
`ifdef CONV_SEG_CFG_CHECK_EN
    output logic                  cfg_err,
`endif
    output logic [2:0]            dbg_state
);

    localparam int               PIR_LOG2 = $clog2(PIXELS_IN_ROW);
    localparam logic [IDX_W-1:0] PIR      = IDX_W'(PIXELS_IN_ROW);
    localparam logic [IDX_W-1:0] PIR_M1   = IDX_W'(PIXELS_IN_ROW - 1);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_EMIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    state_e state_q, state_d;

    // Latched configuration
    logic [IDX_W-1:0] ix_q, ox_start_q, pox_q;
    logic [CFG_W-1:0] k_q, s_q, p_q;
    logic [ROW_W-1:0] n_rows_q;

    // Per-tile derived values, registered in CALC
    logic [IDX_W-1:0] row_start_q, row_end_q, span_q, right_pad_q, first_reg_q, gap_q;
    logic [CFG_W-1:0] left_pad_q, overlap_q;

    // Word walk state
    logic [IDX_W-1:0] adr_q, reg_from_q, gap_cnt_q;
    logic [ROW_W-1:0] row_cnt_q;

    logic cfg_ok;
    logic start_go;

`ifdef CONV_SEG_CFG_CHECK_EN
    assign cfg_ok = (s != '0) && (k != '0) && (pox != '0) && (n_rows != '0) && (ox_start != '0);
`else
    assign cfg_ok = 1'b1;
`endif

    assign start_go = (state_q == ST_IDLE) && start && cfg_ok;

    // ------------------------------------------------------------------
    // Span arithmetic, evaluated from the latched config during CALC
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] k_x, s_x, p_x, p_plus1;
    logic [IDX_W-1:0] ix_start_c, ix_end_c, left_pad_c, right_pad_c, overlap_c;
    logic [IDX_W-1:0] row_start_c, row_end_c, row_end_cap_c, row_end_fix_c;
    logic [IDX_W-1:0] span_c, words_c, gap_c, first_reg_c;

    assign k_x     = IDX_W'(k_q);
    assign s_x     = IDX_W'(s_q);
    assign p_x     = IDX_W'(p_q);
    assign p_plus1 = p_x + ONE;

    assign ix_start_c  = (ox_start_q - ONE) * s_x + ONE;
    assign ix_end_c    = ix_start_c + (pox_q - ONE) * s_x + k_x - ONE;
    assign left_pad_c  = (ix_start_c <= p_x) ? (p_x - ix_start_c + ONE) : '0;
    assign right_pad_c = (ix_end_c > ix_q + p_x) ? (ix_end_c - ix_q - p_x) : '0;
    assign overlap_c   = (ix_start_c <= p_plus1) ? '0 : p_x;
    assign row_start_c = ix_start_c + left_pad_c + overlap_c - p_plus1;
    assign row_end_c   = ix_end_c - right_pad_c - p_plus1;

    // Rounding row_end+1 up to a word boundary and stepping back one lands on row_end | (PIR-1).
    assign row_end_cap_c = row_end_c | PIR_M1;
    assign row_end_fix_c = (row_end_cap_c < ix_q - ONE) ? row_end_cap_c : (ix_q - ONE);
    assign span_c        = row_end_fix_c - row_start_c;
    assign words_c       = (span_c >> PIR_LOG2) + ONE;
    assign gap_c         = (k_x > words_c) ? (k_x - words_c) : '0;
    assign first_reg_c   = left_pad_c + overlap_c + ONE;

    // ------------------------------------------------------------------
    // Current word
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] row_idx, reg_to;
    logic             is_first, is_last, hs;
    logic             row_final_emit, row_final_gap;

    assign row_idx  = row_start_q + adr_q;
    assign is_first = (adr_q == '0);
    assign is_last  = ({1'b0, adr_q} + {1'b0, PIR}) > {1'b0, span_q};
    assign reg_to   = (({1'b0, row_idx} + {1'b0, PIR_M1}) > {1'b0, row_end_q})
                      ? (reg_from_q + row_end_q - row_idx)
                      : (reg_from_q + PIR_M1);

    // A descriptor transfers on a rising edge where seg_valid && seg_ready. While seg_valid
    // is high and seg_ready low the descriptor holds; seg_valid only falls after a transfer,
    // or on abort/reset.
    assign hs = (state_q == ST_EMIT) && seg.seg_ready;

    assign row_final_emit = ((row_cnt_q + ROW_ONE) == n_rows_q);
    assign row_final_gap  = (row_cnt_q == n_rows_q);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_go) state_d = ST_CALC;
            end
            ST_CALC: state_d = ST_EMIT;
            ST_EMIT: begin
                if (hs && is_last) begin
                    if (gap_q != '0)         state_d = ST_GAP;
                    else if (row_final_emit) state_d = ST_DONE;
                    else                     state_d = ST_EMIT;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == ONE) state_d = row_final_gap ? ST_DONE : ST_EMIT;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ix_q        <= '0;
            ox_start_q  <= '0;
            pox_q       <= '0;
            k_q         <= '0;
            s_q         <= '0;
            p_q         <= '0;
            n_rows_q    <= '0;
            row_start_q <= '0;
            row_end_q   <= '0;
            span_q      <= '0;
            right_pad_q <= '0;
            first_reg_q <= '0;
            gap_q       <= '0;
            left_pad_q  <= '0;
            overlap_q   <= '0;
            adr_q       <= '0;
            reg_from_q  <= '0;
            gap_cnt_q   <= '0;
            row_cnt_q   <= '0;
        end else begin
            if (start_go) begin
                ix_q       <= ix;
                ox_start_q <= ox_start;
                pox_q      <= pox;
                k_q        <= k;
                s_q        <= s;
                p_q        <= p;
                n_rows_q   <= n_rows;
            end
            if (state_q == ST_CALC) begin
                row_start_q <= row_start_c;
                row_end_q   <= row_end_c;
                span_q      <= span_c;
                right_pad_q <= right_pad_c;
                first_reg_q <= first_reg_c;
                gap_q       <= gap_c;
                left_pad_q  <= CFG_W'(left_pad_c);
                overlap_q   <= CFG_W'(overlap_c);
                adr_q       <= '0;
                reg_from_q  <= first_reg_c;
                row_cnt_q   <= '0;
            end
            if (hs) begin
                if (is_last) begin
                    // Every row replays the same words, so the walk rewinds here.
                    adr_q      <= '0;
                    reg_from_q <= first_reg_q;
                    row_cnt_q  <= row_cnt_q + ROW_ONE;
                    gap_cnt_q  <= gap_q;
                end else begin
                    adr_q      <= adr_q + PIR;
                    reg_from_q <= reg_to + ONE;
                end
            end
            if (state_q == ST_GAP) begin
                gap_cnt_q <= gap_cnt_q - ONE;
            end
        end
    end

`ifdef CONV_SEG_CFG_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= (state_q == ST_IDLE) && start && !cfg_ok;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs; descriptor fields read zero outside EMIT
    // ------------------------------------------------------------------
    assign seg.seg_valid = (state_q == ST_EMIT);
    assign done          = (state_q == ST_DONE);
    assign busy          = (state_q != ST_IDLE);
    assign dbg_state     = state_q;

    always_comb begin
        seg.row_start_idx = '0;
        seg.row_end_idx   = '0;
        seg.reg_start_idx = '0;
        seg.reg_end_idx   = '0;
        seg.west_pad      = '0;
        seg.slab_num      = '0;
        seg.east_pad      = '0;
        seg.seg_last      = 1'b0;
        if (state_q == ST_EMIT) begin
            seg.row_start_idx = row_idx;
            seg.row_end_idx   = row_idx + PIR_M1;
            seg.reg_start_idx = reg_from_q;
            seg.reg_end_idx   = is_last ? (reg_to + right_pad_q) : reg_to;
            seg.west_pad      = is_first ? left_pad_q : '0;
            seg.slab_num      = is_first ? overlap_q : '0;
            seg.east_pad      = is_last ? CFG_W'(right_pad_q) : '0;
            seg.seg_last      = is_last;
        end
    end

endmodule

// File: tb/tb_conv_row_segmenter.sv
// Randomized and directed bench for conv_row_segmenter against a list-based row model.
module tb_conv_row_segmenter;

  localparam int PIR = 32;
  localparam int DW  = 77;

  typedef struct {
    int ix;
    int ox_start;
    int pox;
    int k;
    int s;
    int p;
    int n_rows;
  } cfg_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [15:0] ix;
  logic [15:0] ox_start;
  logic [15:0] pox;
  logic [3:0]  k;
  logic [3:0]  s;
  logic [3:0]  p;
  logic [3:0]  n_rows;
  logic        done;
  logic        busy;
  logic [2:0]  dbg_state;
`ifdef CONV_SEG_CFG_CHECK_EN
  logic        cfg_err;
`endif

  conv_row_segmenter_if #(.IDX_W(16), .CFG_W(4)) seg_if ();

  conv_row_segmenter #(
    .PIXELS_IN_ROW(PIR), .IDX_W(16), .CFG_W(4), .ROW_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .ix(ix), .ox_start(ox_start), .pox(pox), .k(k), .s(s), .p(p), .n_rows(n_rows),
    .seg(seg_if), .done(done), .busy(busy),
`ifdef CONV_SEG_CFG_CHECK_EN
    .cfg_err(cfg_err),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] row_q[$];
  int exp_gap;
  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] observed();
    return {seg_if.row_start_idx, seg_if.row_end_idx, seg_if.reg_start_idx, seg_if.reg_end_idx,
            seg_if.west_pad, seg_if.slab_num, seg_if.east_pad, seg_if.seg_last};
  endfunction

  // Reference: one row as a list of words, straight from the span formulas in plain integers.
  function automatic bit model_row(input cfg_t c);
    int ixs, ixe, lp, rp, ov, rs, re, rfix, rf, rt, rsi, adr, words;
    bit last;
    logic [15:0] f_rs, f_re, f_gs, f_ge;
    logic [3:0]  f_w, f_sl, f_e;
    row_q.delete();
    ixs  = (c.ox_start - 1) * c.s + 1;
    ixe  = ixs + (c.pox - 1) * c.s + c.k - 1;
    lp   = (ixs <= c.p) ? c.p - ixs + 1 : 0;
    rp   = (ixe > c.ix + c.p) ? ixe - c.ix - c.p : 0;
    ov   = (ixs <= c.p + 1) ? 0 : c.p;
    rs   = ixs + lp + ov - (c.p + 1);
    re   = ixe - rp - (c.p + 1);
    rfix = ((re + 1 + PIR - 1) / PIR) * PIR - 1;
    if (rfix > c.ix - 1) rfix = c.ix - 1;
    if (re < rs || rfix < rs || ixe > c.ix + 2 * c.p || ixs > c.ix) return 1'b0;
    rf = lp + ov + 1;
    adr = 0;
    words = 0;
    do begin
      rsi  = rs + adr;
      rt   = (rsi + PIR - 1 > re) ? rf + (re - rsi) : rf + PIR - 1;
      last = (adr + PIR > rfix - rs);
      f_rs = 16'(rsi);
      f_re = 16'(rsi + PIR - 1);
      f_gs = 16'(rf);
      f_ge = 16'(rt + (last ? rp : 0));
      f_w  = (adr == 0) ? 4'(lp) : 4'd0;
      f_sl = (adr == 0) ? 4'(ov) : 4'd0;
      f_e  = last ? 4'(rp) : 4'd0;
      row_q.push_back({f_rs, f_re, f_gs, f_ge, f_w, f_sl, f_e, last});
      rf = rt + 1;
      adr += PIR;
      words++;
    end while (!last);
    exp_gap = (c.k > words) ? c.k - words : 0;
    return 1'b1;
  endfunction

  // drivers
  task automatic drive_cfg(input cfg_t c);
    ix       = 16'(c.ix);
    ox_start = 16'(c.ox_start);
    pox      = 16'(c.pox);
    k        = 4'(c.k);
    s        = 4'(c.s);
    p        = 4'(c.p);
    n_rows   = 4'(c.n_rows);
  endtask

  task automatic pick_cfg(output cfg_t c);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 500 && !ok; t++) begin
      c.ix       = $urandom_range(8, 200);
      c.ox_start = $urandom_range(1, 20);
      c.pox      = $urandom_range(1, 40);
      c.k        = $urandom_range(1, 7);
      c.s        = $urandom_range(1, 4);
      c.p        = $urandom_range(0, 3);
      c.n_rows   = $urandom_range(1, 4);
      ok = model_row(c);
    end
    if (!ok) c = '{64, 1, 32, 3, 1, 1, 2};
  endtask

  // mode: 0 ready always, 1 ready every other cycle, 2 random ready
  task automatic run_job(input string name, input cfg_t c, input int mode,
                         input int abort_word, input bit poke_start);
    logic [DW-1:0] exp_d;
    int cyc, hs, gap_seen, words;
    bit in_gap, finished, done_seen;
    exp_q.delete();
    if (!model_row(c)) check_eq({name, "/cfg_model"}, 80'(0), 80'(1));
    words = row_q.size();
    for (int r = 0; r < c.n_rows; r++) begin
      foreach (row_q[i]) exp_q.push_back(row_q[i]);
    end
    @(negedge clk);
    check_eq({name, "/idle_busy"}, 80'(busy), 80'(0));
    drive_cfg(c);
    start = 1'b1;
    cyc = 0; hs = 0; gap_seen = 0; in_gap = 1'b0; finished = 1'b0;
    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      if (poke_start && cyc == 3) begin
        start = 1'b1;
        ix = ix ^ 16'h0005;
      end
      case (mode)
        0:       seg_if.seg_ready = 1'b1;
        1:       seg_if.seg_ready = cyc[0];
        default: seg_if.seg_ready = ($urandom_range(0, 9) < 7);
      endcase
      if (cyc == 1) check_eq({name, "/calc"}, 80'({seg_if.seg_valid, busy}), 80'(2'b01));
      if (cyc == 2) check_eq({name, "/first_valid"}, 80'(seg_if.seg_valid), 80'(1));
      if (seg_if.seg_valid) begin
        if (in_gap) begin
          check_eq({name, "/gap"}, 80'(gap_seen), 80'(exp_gap));
          in_gap = 1'b0;
        end
        if (exp_q.size() == 0) begin
          check_eq({name, "/extra_desc"}, 80'(1), 80'(0));
          finished = 1'b1;
        end else if (seg_if.seg_ready) begin
          hs++;
          exp_d = exp_q.pop_front();
          check_eq({name, "/desc"}, 80'(observed()), 80'(exp_d));
          if (exp_d[0]) begin
            in_gap = 1'b1;
            gap_seen = 0;
          end
          if (hs == abort_word) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            check_eq({name, "/abort_idle"}, 80'({seg_if.seg_valid, busy}), 80'(0));
            done_seen = 1'b0;
            repeat (5) begin
              @(negedge clk);
              done_seen = done_seen | done | seg_if.seg_valid;
            end
            check_eq({name, "/abort_quiet"}, 80'(done_seen), 80'(0));
            finished = 1'b1;
          end
        end else begin
          check_eq({name, "/hold"}, 80'(observed()), 80'(exp_q[0]));
        end
      end else if (done) begin
        if (in_gap) check_eq({name, "/gap"}, 80'(gap_seen), 80'(exp_gap));
        in_gap = 1'b0;
        check_eq({name, "/rows_left"}, 80'(exp_q.size()), 80'(0));
        if (mode == 0)
          check_eq({name, "/done_lat"}, 80'(cyc), 80'(2 + c.n_rows * (words + exp_gap)));
        @(negedge clk);
        start = 1'b0;
        check_eq({name, "/done_pulse"}, 80'({done, busy}), 80'(0));
        finished = 1'b1;
      end else if (in_gap) begin
        gap_seen++;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (!finished) check_eq({name, "/timeout"}, 80'(0), 80'(1));
  endtask

  cfg_t t1, t2, t3, t4, rc;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    seg_if.seg_ready = 1'b0;
    drive_cfg('{0, 0, 0, 0, 0, 0, 0});
    repeat (2) @(negedge clk);
    check_eq("rst_out", 80'({seg_if.seg_valid, busy, done, seg_if.row_start_idx, seg_if.reg_end_idx}), 80'(0));
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_idle", 80'({seg_if.seg_valid, busy, done}), 80'(0));

    t1 = '{64, 1, 32, 3, 1, 1, 1};
    t2 = '{64, 1, 16, 3, 2, 1, 1};
    t3 = '{32, 1, 32, 3, 1, 1, 1};
    t4 = '{64, 1, 32, 3, 1, 1, 3};
    run_job("t1", t1, 0, -1, 1'b0);
    run_job("t2", t2, 0, -1, 1'b0);
    run_job("t3", t3, 0, -1, 1'b0);
    run_job("t4", t4, 1, -1, 1'b0);
    run_job("t5_abort", t1, 0, 2, 1'b0);
    run_job("t5_rerun", t1, 0, -1, 1'b0);

    // asynchronous reset in the middle of a row
    @(negedge clk);
    drive_cfg(t1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seg_if.seg_ready = 1'b0;
    @(negedge clk);
    check_eq("t6_pre", 80'({seg_if.seg_valid, seg_if.reg_start_idx}), 80'({1'b1, 16'd2}));
    #2 reset_n = 1'b0;
    #1 check_eq("t6_async", 80'({seg_if.seg_valid, busy, seg_if.reg_start_idx, seg_if.west_pad}), 80'(0));
    @(negedge clk);
    reset_n = 1'b1;
    run_job("t6_rerun", t1, 0, -1, 1'b0);

`ifdef CONV_SEG_CFG_CHECK_EN
    begin
      bit quiet;
      @(negedge clk);
      drive_cfg('{64, 1, 32, 3, 0, 1, 1});
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("cfg_err_pulse", 80'({cfg_err, busy}), 80'(2'b10));
      @(negedge clk);
      check_eq("cfg_err_drop", 80'(cfg_err), 80'(0));
      quiet = 1'b0;
      repeat (5) begin
        @(negedge clk);
        quiet = quiet | seg_if.seg_valid | done | busy;
      end
      check_eq("cfg_err_quiet", 80'(quiet), 80'(0));
    end
`endif

    for (int j = 0; j < 30; j++) begin
      pick_cfg(rc);
      run_job($sformatf("rnd%0d", j), rc, $urandom_range(0, 2), -1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
